// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time for a bounded
// burst and drives the async FIFO write side directly, stalling on wr_full.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           wr_clk,
    input  logic                           wr_rstn,
    input  logic                           arb_en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wr_full,
    output logic                           wr_en,
    output logic [DATA_SIZE-1:0]           wr_data,
    output logic                           grant_valid,
    output logic [ID_W-1:0]                grant_id,
    output logic [15:0]                    wr_count
);

    localparam int unsigned BC_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt, grant_id_nxt;
    logic [BC_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [15:0]     wr_count_nxt;
    logic [ID_W:0]   sel;
    logic            rel;

    // Circular search from ptr; returns {found, index}.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(NUM_REQ);
            if (vld[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            wr_count    <= '0;
        end else begin
            state       <= state_nxt;
            grant_valid <= (state_nxt == GRANT);
            grant_id    <= grant_id_nxt;
            rr_ptr      <= rr_ptr_nxt;
            burst_cnt   <= burst_cnt_nxt;
            wr_count    <= wr_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_id_nxt  = grant_id;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        wr_count_nxt  = wr_count;
        req_ready     = '0;
        wr_en         = 1'b0;
        wr_data       = '0;
        sel           = '0;
        rel           = 1'b0;

        case (state)
            IDLE: begin
                sel = pick(req_valid, rr_ptr);
                if (arb_en && sel[ID_W]) begin
                    state_nxt     = GRANT;
                    grant_id_nxt  = sel[ID_W-1:0];
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                req_ready[grant_id] = ~wr_full;
                wr_en   = req_valid[grant_id] & ~wr_full;
                wr_data = req_data[int'(grant_id)*int'(DATA_SIZE) +: DATA_SIZE];
                if (wr_en) begin
                    burst_cnt_nxt = burst_cnt + BC_W'(1);
                    wr_count_nxt  = wr_count + 16'd1;
                end
                rel = (wr_en && (burst_cnt == BC_W'(MAX_BURST - 1))) || !req_valid[grant_id];
                // On release the granted requester drops to lowest priority and
                // the next winner is picked on the same edge (no bubble).
                if (rel) begin
                    rr_ptr_nxt = ID_W'((int'(grant_id) + 1) % int'(NUM_REQ));
                    sel        = pick(req_valid, rr_ptr_nxt);
                    if (arb_en && sel[ID_W]) begin
                        grant_id_nxt  = sel[ID_W-1:0];
                        burst_cnt_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-driven requesters and a scoreboard
// of expected FIFO beats (requester id + data) in arbitration order.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic              wr_clk = 1'b0;
    logic              wr_rstn;
    logic              arb_en;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              wr_full;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;
    logic [15:0]       wr_count;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [15:0] tb_cnt;
    exp_t        sb[$];
    logic [DW-1:0] src_q[NR][$];

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_BURST(4), .ID_W(IW)) dut (
        .wr_clk      (wr_clk),
        .wr_rstn     (wr_rstn),
        .arb_en      (arb_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wr_full     (wr_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .wr_count    (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int id, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) src_q[id].push_back(base + DW'(k));
    endtask

    task automatic expect_beats(input int id, input logic [DW-1:0] base, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.id   = IW'(id);
            e.data = base + DW'(k);
            sb.push_back(e);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < int'(NR); i++) begin
            req_valid[i] = (src_q[i].size() > 0);
            req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    // One cycle: drive at negedge, check settled outputs, model the handshake at posedge.
    task automatic tick(input bit stream);
        exp_t          e;
        logic [NR-1:0] took;
        logic          we;
        drive_reqs();
        #1;
        chk("wr_count", 32'(wr_count), 32'(tb_cnt));
        if (stream) chk("stream_wr_en", 32'(wr_en), 32'd1);
        if (wr_full) begin
            chk("stall_wr_en", 32'(wr_en), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        if (grant_valid !== 1'b1) chk("idle_outputs", 32'({wr_en, req_ready, wr_data}), 32'd0);
        if (wr_en === 1'b1) begin
            chk("beat_expected", 32'(wr_en), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_data", 32'(wr_data), 32'(e.data));
                chk("beat_id", 32'(grant_id), 32'(e.id));
                chk("beat_ready", 32'(req_ready), 32'd1 << e.id);
            end
        end
        took = req_ready & req_valid;
        we   = wr_en;
        @(posedge wr_clk);
        for (int i = 0; i < int'(NR); i++)
            if (took[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (we === 1'b1) tb_cnt++;
        @(negedge wr_clk);
    endtask

    task automatic wait_beats(input logic [15:0] target);
        int guard = 0;
        while (tb_cnt != target && guard < 200) begin
            tick(1'b0);
            guard++;
        end
        chk("wait_beats", 32'(tb_cnt), 32'(target));
    endtask

    task automatic drain();
        int guard = 0;
        while (!(sb.size() == 0 && grant_valid === 1'b0) && guard < 300) begin
            tick(1'b0);
            guard++;
        end
        chk("drain_sb", 32'(sb.size()), 32'd0);
        chk("drain_idle", 32'(grant_valid), 32'd0);
    endtask

    initial begin
        logic [15:0]   base;
        logic [IW-1:0] exp_id;

        wr_rstn = 1'b0; arb_en = 1'b1; wr_full = 1'b0;
        req_valid = '0; req_data = '0; tb_cnt = '0;

        // Reset values
        repeat (3) @(negedge wr_clk);
        chk("rst_gv", 32'(grant_valid), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        wr_rstn = 1'b1;
        @(negedge wr_clk);
        chk("post_rst_idle", 32'(grant_valid), 32'd0);

        // Round-robin: all four valid, 4-beat bursts, no bubbles
        for (int i = 0; i < 4; i++) load(i, DW'(8'h80 + i*16), 8);
        for (int i = 0; i < 4; i++) expect_beats(i, DW'(8'h80 + i*16), 4);
        for (int i = 0; i < 4; i++) expect_beats(i, DW'(8'h84 + i*16), 4);
        tick(1'b0);
        chk("rr_first_gv", 32'(grant_valid), 32'd1);
        chk("rr_first_gid", 32'(grant_id), 32'd0);
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            if (c == 15) chk("rr_count16", 32'(wr_count), 32'd16);
        end
        drain();

        // Short burst from requester 1, then requester 3 takes over
        load(1, 8'h21, 2); load(3, 8'h31, 2);
        expect_beats(1, 8'h21, 2); expect_beats(3, 8'h31, 2);
        drain();

        // Full stall after the 2nd beat of a 4-beat burst
        load(0, 8'h41, 4); expect_beats(0, 8'h41, 4);
        base = tb_cnt;
        wait_beats(base + 16'd2);
        wr_full = 1'b1;
        repeat (5) begin
            tick(1'b0);
            chk("stall_gv", 32'(grant_valid), 32'd1);
            chk("stall_gid", 32'(grant_id), 32'd0);
        end
        wr_full = 1'b0;
        drain();

        // arb_en dropped during requester 0's burst
        load(0, 8'h50, 8);
        expect_beats(0, 8'h50, 4); expect_beats(1, 8'h60, 4); expect_beats(0, 8'h54, 4);
        base = tb_cnt;
        wait_beats(base + 16'd1);
        arb_en = 1'b0;
        load(1, 8'h60, 4);
        wait_beats(base + 16'd4);
        chk("arb_off_idle", 32'(grant_valid), 32'd0);
        repeat (3) begin
            tick(1'b0);
            chk("arb_off_gv", 32'(grant_valid), 32'd0);
        end
        arb_en = 1'b1;
        tick(1'b0);
        chk("arb_on_gv", 32'(grant_valid), 32'd1);
        chk("arb_on_gid", 32'(grant_id), 32'd1);
        drain();

        // Asynchronous reset mid-burst
        load(2, 8'hB0, 4); expect_beats(2, 8'hB0, 4);
        base = tb_cnt;
        wait_beats(base + 16'd2);
        wr_rstn = 1'b0;
        #1;
        chk("mid_rst_gv", 32'(grant_valid), 32'd0);
        chk("mid_rst_gid", 32'(grant_id), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_count", 32'(wr_count), 32'd0);
        sb.delete();
        for (int i = 0; i < int'(NR); i++) src_q[i].delete();
        tb_cnt = '0;
        load(2, 8'hA0, 2); expect_beats(2, 8'hA0, 2);
        drive_reqs();
        @(negedge wr_clk);
        chk("in_rst_wr_en", 32'(wr_en), 32'd0);
        wr_rstn = 1'b1;
        tick(1'b0);
        chk("rst_regrant_gv", 32'(grant_valid), 32'd1);
        chk("rst_regrant_gid", 32'(grant_id), 32'd2);
        drain();

        // Counter wrap: 65536 continuous beats, rr_ptr starts at 3
        req_valid = 4'hF;
        req_data  = {8'h03, 8'h02, 8'h01, 8'h00};
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("wrap_first_gid", 32'(grant_id), 32'd3);
        for (int j = 0; j < 65536; j++) begin
            exp_id = IW'((3 + j / 4) % 4);
            chk("wrap_wr_en", 32'(wr_en), 32'd1);
            chk("wrap_gid", 32'(grant_id), 32'(exp_id));
            chk("wrap_data", 32'(wr_data), 32'(exp_id));
            chk("wrap_count", 32'(wr_count), 32'(tb_cnt));
            @(posedge wr_clk);
            tb_cnt++;
            @(negedge wr_clk);
            if (tb_cnt == 16'd0) chk("wrap_zero", 32'(wr_count), 32'd0);
        end
        req_valid = '0;
        repeat (2) @(negedge wr_clk);
        chk("wrap_end_idle", 32'(grant_valid), 32'd0);
        chk("wrap_end_count", 32'(wr_count), 32'(tb_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
